// File: rtl/line_mem_responder.sv
// Lower-memory responder for cache line fill/writeback: one 256-bit line served as eight
// 32-bit word accesses to a backing RAM. Optional macro: LINE_MEM_CRITICAL_WORD_FIRST_EN.
module line_mem_responder #(
    parameter int DEPTH_W = 12,
    parameter int LAT     = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [31:0]  req_addr,
    input  logic [255:0] req_line,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic         resp_write,
    output logic [255:0] resp_line,
    output logic         busy
);
    // state    | meaning
    // S_IDLE   | waiting for a line request, req_ready high
    // S_ACCESS | latency countdown and eight word accesses
    // S_RESP   | response held until resp_ready
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam int         LINE_W     = DEPTH_W - 3;
    localparam logic [3:0] LAT_RELOAD = 4'(LAT);

    state_t             state;
    logic [31:0]        mem [0:(1 << DEPTH_W) - 1];
    logic [LINE_W-1:0]  line_q;
    logic [255:0]       wline_q;
    logic               wr_q;
    logic [2:0]         beat;
    logic [2:0]         done_cnt;
    logic [3:0]         lat_cnt;
    logic [2:0]         start_beat;
    logic [DEPTH_W-1:0] mem_idx;
    logic [31:0]        rd_word;
    logic [31:0]        wr_word;
    logic               access_now;
    logic               mem_we;
    logic               unused_addr;

`ifdef LINE_MEM_CRITICAL_WORD_FIRST_EN
    assign start_beat = req_addr[4:2];
`else
    assign start_beat = 3'd0;
`endif

    // Only the line-index bits (and the word bits with critical-word-first) matter.
    assign unused_addr = ^req_addr;

    assign mem_idx    = {line_q, beat};
    assign rd_word    = mem[mem_idx];
    assign wr_word    = wline_q[{beat, 5'd0} +: 32];
    assign access_now = (state == S_ACCESS) && (lat_cnt == 4'd0);
    // A beat coinciding with reset must not land in the RAM.
    assign mem_we     = access_now && wr_q && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_write <= 1'b0;
            resp_line  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        line_q     <= req_addr[DEPTH_W+1:5];
                        wline_q    <= req_line;
                        wr_q       <= req_write;
                        resp_write <= req_write;
                        beat       <= start_beat;
                        done_cnt   <= 3'd0;
                        lat_cnt    <= LAT_RELOAD;
                        req_ready  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else begin
                        resp_line[{beat, 5'd0} +: 32] <= wr_q ? wr_word : rd_word;
                        beat     <= beat + 3'd1;
                        done_cnt <= done_cnt + 3'd1;
                        lat_cnt  <= LAT_RELOAD;
                        if (done_cnt == 3'd7) begin
                            resp_valid <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a LAT=0 and a LAT=2 instance checked against a line-level
// memory model with directed and random fill/writeback traffic.
module tb_line_mem_responder;
    logic         clk = 1'b0;
    logic         rst        [2];
    logic         req_valid  [2];
    logic         req_ready  [2];
    logic         req_write  [2];
    logic [31:0]  req_addr   [2];
    logic [255:0] req_line   [2];
    logic         resp_valid [2];
    logic         resp_ready [2];
    logic         resp_write [2];
    logic [255:0] resp_line  [2];
    logic         busy       [2];

    always #5 clk = ~clk;

    line_mem_responder #(.DEPTH_W(12), .LAT(0)) u_dut_lat0 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_line(req_line[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_write(resp_write[0]),
        .resp_line(resp_line[0]), .busy(busy[0])
    );

    line_mem_responder #(.DEPTH_W(12), .LAT(2)) u_dut_lat2 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_line(req_line[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_write(resp_write[1]),
        .resp_line(resp_line[1]), .busy(busy[1])
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference memory: one 256-bit line per line index (512 lines at DEPTH_W=12).
    logic [255:0] ref_line [2][512];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lidx(input logic [31:0] a);
        return int'((a / 32) % 512);
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    function automatic int start_of(input logic [31:0] a);
`ifdef LINE_MEM_CRITICAL_WORD_FIRST_EN
        return int'((a / 4) % 8);
`else
        return 0;
`endif
    endfunction

    // Apply the first nbeats word writes of a writeback, in access order.
    task automatic model_write(input int i, input logic [31:0] addr, input logic [255:0] line,
                               input int nbeats);
        int li;
        int k;
        li = lidx(addr);
        for (int j = 0; j < nbeats; j++) begin
            k = (start_of(addr) + j) % 8;
            ref_line[i][li][k*32 +: 32] = line[k*32 +: 32];
        end
    endtask

    task automatic chk_idle(input int i, input string tag);
        chk({tag, "_idle"}, {253'd0, req_ready[i], busy[i], resp_valid[i]}, 256'd4);
    endtask

    task automatic txn(input int i, input bit wr, input logic [31:0] addr,
                       input logic [255:0] line, input int bp, input bit pulse, input string tag);
        int           cyc;
        logic [255:0] expl;
        logic [255:0] held;
        expl = wr ? line : ref_line[i][lidx(addr)];
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i]  = addr;
        req_line[i]  = line;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        req_write[i] = ~wr;
        req_line[i]  = {8{$urandom()}};
        if (wr) model_write(i, addr, line, 8);
        cyc = 0;
        while (resp_valid[i] !== 1'b1 && cyc < 300) begin
            chk({tag, "_rdy_busy"}, {254'd0, req_ready[i], busy[i]}, 256'd1);
            if (pulse && cyc == 4) begin
                req_valid[i] = 1'b1;
                req_write[i] = 1'b1;
                req_addr[i]  = addr;
                req_line[i]  = ~line;
            end else begin
                req_valid[i] = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        req_valid[i] = 1'b0;
        chk({tag, "_latency"}, 256'(cyc), 256'(8 * (lat_of(i) + 1)));
        chk({tag, "_line"}, resp_line[i], expl);
        chk({tag, "_write"}, {255'd0, resp_write[i]}, {255'd0, wr});
        held = resp_line[i];
        for (int b = 0; b < bp; b++) begin
            resp_ready[i] = 1'b0;
            @(posedge clk); #1;
            chk({tag, "_bp_valid"}, {255'd0, resp_valid[i]}, 256'd1);
            chk({tag, "_bp_line"}, resp_line[i], held);
        end
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready[i] = 1'b0;
        chk_idle(i, tag);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] old_l;
        logic [255:0] new_l;
        logic [255:0] tmp;
        logic [31:0]  a;
        int           li;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i] = '0;
            req_line[i] = '0;
            resp_ready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b0;
            chk_idle(i, "por");
            chk("por_resp_line", resp_line[i], 256'd0);
            chk("por_resp_write", {255'd0, resp_write[i]}, 256'd0);
        end

        // LAT=0: writeback then fill of the same line, backpressure, aliasing.
        for (int k = 0; k < 8; k++) tmp[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        txn(0, 1'b1, 32'h0000_0040, tmp, 0, 1'b0, "wb40");
        txn(0, 1'b0, 32'h0000_0040, '0, 0, 1'b0, "fill40");
        chk("fill40_const", resp_line[0] === 256'd0 ? 256'd0 : ref_line[0][2], tmp);
        txn(0, 1'b0, 32'h0000_0040, '0, 5, 1'b0, "bp5");
        for (int k = 0; k < 8; k++) tmp[k*32 +: 32] = 32'h5A00_0000 + 32'(k * 3);
        txn(0, 1'b1, 32'h0000_4040, tmp, 0, 1'b0, "wb_alias");
        txn(0, 1'b0, 32'h0000_0040, '0, 0, 1'b0, "fill_alias");

        // LAT=2: fill with a stray request pulse mid-access, then refill.
        txn(1, 1'b1, 32'h0000_0040, {8{32'hC3C3_1234}} ^ {8{$urandom()}}, 0, 1'b0, "l2_wb");
        txn(1, 1'b0, 32'h0000_0040, '0, 0, 1'b1, "l2_fill_pulse");
        txn(1, 1'b0, 32'h0000_0040, '0, 2, 1'b0, "l2_refill");

        // Reset in the middle of a LAT=2 fill.
        req_valid[1] = 1'b1;
        req_write[1] = 1'b0;
        req_addr[1]  = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst[1] = 1'b0;
        chk_idle(1, "rst_mid");
        chk("rst_mid_line", resp_line[1], 256'd0);
        txn(1, 1'b0, 32'h0000_0040, '0, 0, 1'b0, "l2_after_rst");

        // Writeback aborted by reset on its 4th access edge.
        for (int k = 0; k < 8; k++) begin
            old_l[k*32 +: 32] = 32'h0111_0000 + 32'(k);
            new_l[k*32 +: 32] = 32'h0EEE_0000 + 32'(k);
        end
        txn(0, 1'b1, 32'h0000_0060, old_l, 0, 1'b0, "pre60");
`ifdef LINE_MEM_CRITICAL_WORD_FIRST_EN
        a = 32'h0000_0074;
`else
        a = 32'h0000_0060;
`endif
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = a;
        req_line[0]  = new_l;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        chk_idle(0, "abort");
        chk("abort_line", resp_line[0], 256'd0);
        model_write(0, a, new_l, 3);
        txn(0, 1'b0, 32'h0000_0060, '0, 0, 1'b0, "abort_fill");

        // Random traffic over lines 8..15 with random alias and ignored low bits.
        for (int i = 0; i < 2; i++) begin
            for (int l = 8; l < 16; l++) begin
                for (int k = 0; k < 8; k++) tmp[k*32 +: 32] = $urandom();
                txn(i, 1'b1, 32'(l * 32), tmp, 0, 1'b0, "rnd_init");
            end
            for (int t = 0; t < 30; t++) begin
                li = 8 + int'($urandom_range(0, 7));
                a = $urandom();
                a[13:5] = 9'(li);
                for (int k = 0; k < 8; k++) tmp[k*32 +: 32] = $urandom();
                txn(i, 1'($urandom_range(0, 1)), a, tmp, int'($urandom_range(0, 2)), 1'b0, "rnd");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
